// File: rtl/word_pair_ser.sv
// Two-bit-per-cycle serialiser: a W-bit word leaves as W/2 (A,B) pairs, LSB pair first.
// A load accepted on the final pair's edge chains the next word with no idle gap.
module word_pair_ser #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         hold,
  output logic         ready,
  output logic         A,
  output logic         B,
  output logic         frame,
  output logic         last
);

  localparam int NP    = W / 2;
  localparam int KW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int LASTK = NP - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_n;
  logic [KW-1:0]  k, k_n;
  logic [W-1:0]   sr, sr_n;
  logic           a_n, b_n, frame_n, last_n;
  logic           at_last;

  assign at_last = (state == SHIFT) && (k == KW'(LASTK));
  assign ready   = (state == IDLE) || (at_last && !hold);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      k     <= '0;
      sr    <= '0;
      A     <= 1'b0;
      B     <= 1'b0;
      frame <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      sr    <= sr_n;
      A     <= a_n;
      B     <= b_n;
      frame <= frame_n;
      last  <= last_n;
    end
  end

  // sr holds the pairs not yet presented; pair 0 goes straight to A/B on acceptance
  always_comb begin
    state_n = state;
    k_n     = k;
    sr_n    = sr;
    a_n     = A;
    b_n     = B;
    frame_n = frame;
    last_n  = last;
    if (load && ready) begin
      state_n = SHIFT;
      k_n     = '0;
      a_n     = din[0];
      b_n     = din[1];
      sr_n    = {2'b00, din[W-1:2]};
      frame_n = 1'b1;
      last_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        SHIFT: begin
          if (!hold) begin
            if (at_last) begin
              state_n = IDLE;
              k_n     = '0;
              sr_n    = '0;
              a_n     = 1'b0;
              b_n     = 1'b0;
              frame_n = 1'b0;
              last_n  = 1'b0;
            end else begin
              k_n    = k + KW'(1);
              a_n    = sr[0];
              b_n    = sr[1];
              sr_n   = {2'b00, sr[W-1:2]};
              last_n = (k_n == KW'(LASTK));
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_pair_ser.sv
// Directed bench for word_pair_ser (W=32) with a pair scoreboard filled on each accepted load.
module tb_word_pair_ser;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr, load, hold;
  logic [W-1:0] din;
  logic         ready, A, B, frame, last;

  int passed = 0;
  int total  = 0;
  int fcnt   = 0;

  bit       m_idle = 1'b1;
  bit [1:0] q[$];
  bit [1:0] cur = 2'b00;

  word_pair_ser #(.W(W)) dut (
    .clk(clk), .clr(clr), .load(load), .din(din), .hold(hold),
    .ready(ready), .A(A), .B(B), .frame(frame), .last(last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one clock: check ready before the edge, update the model at the edge, check outputs after
  task automatic tick(input string tag);
    bit acc;
    bit exp_ready;
    #1;
    exp_ready = m_idle || (q.size() == 0 && !hold);
    chk({tag, ".ready"}, ready, exp_ready);
    acc = !clr && load && exp_ready;
    @(posedge clk);
    if (clr) begin
    end else if (acc) begin
      q.delete();
      for (int i = 0; i < W / 2; i++) q.push_back({din[2*i+1], din[2*i]});
      cur    = q.pop_front();
      m_idle = 1'b0;
    end else if (!m_idle && !hold) begin
      if (q.size() != 0) cur = q.pop_front();
      else begin
        m_idle = 1'b1;
        cur    = 2'b00;
      end
    end
    #1;
    chk({tag, ".A"}, A, cur[0]);
    chk({tag, ".B"}, B, cur[1]);
    chk({tag, ".frame"}, frame, !m_idle);
    chk({tag, ".last"}, last, !m_idle && q.size() == 0);
    if (frame) fcnt++;
  endtask

  task automatic run_to_idle(input string tag);
    for (int i = 0; i < 40 && !m_idle; i++) tick(tag);
    chk({tag, ".idle_reached"}, m_idle, 1'b1);
  endtask

  initial begin
    clr = 1'b1; load = 1'b1; hold = 1'b0; din = 32'hDEADBEEF;
    #2;
    chk("rst.A", A, 1'b0);
    chk("rst.B", B, 1'b0);
    chk("rst.frame", frame, 1'b0);
    chk("rst.last", last, 1'b0);
    tick("rst_load_ignored");

    // release with load already high: first edge after release accepts
    clr = 1'b0; din = 32'h37353AF2; fcnt = 0;
    tick("w1_accept");
    chk("w1.first_pair", {B, A}, 2'b10);
    load = 1'b0; din = 32'h0;
    tick("w1_p1");
    chk("w1.second_pair", {B, A}, 2'b00);
    tick("w1_p2");
    chk("w1.third_pair", {B, A}, 2'b11);
    run_to_idle("w1");
    chk("w1.frames", fcnt, 16);

    // back-to-back words
    load = 1'b1; din = 32'hFFFFFFFF; fcnt = 0;
    tick("bb_a");
    load = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick("bb_a");
    chk("bb.last_before_chain", last, 1'b1);
    load = 1'b1; din = 32'h00000000;
    tick("bb_b");
    chk("bb.chain_frame", frame, 1'b1);
    load = 1'b0;
    run_to_idle("bb");
    chk("bb.frames", fcnt, 32);

    // hold 3 cycles at k=5
    load = 1'b1; din = 32'hA5C3_1E96; fcnt = 0;
    tick("h5_accept");
    load = 1'b0;
    repeat (5) tick("h5_run");
    hold = 1'b1;
    repeat (3) tick("h5_hold");
    hold = 1'b0;
    run_to_idle("h5");
    chk("h5.frames", fcnt, 19);

    // hold on last pair, load during hold ignored
    load = 1'b1; din = 32'h1234_5678;
    tick("h15_accept");
    load = 1'b0;
    repeat (15) tick("h15_run");
    hold = 1'b1; load = 1'b1; din = 32'hFFFF_0000;
    tick("h15_hold");
    chk("h15.last_held", last, 1'b1);
    hold = 1'b0; load = 1'b0;
    tick("h15_release");
    chk("h15.idle_after", frame, 1'b0);

    // async clear at k=8
    load = 1'b1; din = 32'h9ABC_DEF1;
    tick("clr_accept");
    load = 1'b0;
    repeat (8) tick("clr_run");
    #2 clr = 1'b1;
    #1;
    chk("clr.async_frame", frame, 1'b0);
    chk("clr.async_AB", {B, A}, 2'b00);
    q.delete(); m_idle = 1'b1; cur = 2'b00;
    load = 1'b1;
    tick("clr_held");
    clr = 1'b0; load = 1'b0;
    repeat (2) tick("clr_idle");
    load = 1'b1; din = 32'h0000_0006;
    tick("clr_new");
    chk("clr.new_pair0", {B, A}, 2'b10);
    load = 1'b0;
    run_to_idle("clr_new");

    // load mid-word ignored; hold in IDLE does not block acceptance
    load = 1'b1; hold = 1'b1; din = 32'hC0FF_EE11;
    tick("mid_accept");
    hold = 1'b0; load = 1'b0;
    repeat (3) tick("mid_run");
    load = 1'b1; din = 32'h5555_5555;
    tick("mid_ignored");
    load = 1'b0;
    run_to_idle("mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/word_pair_ser.md
WORD_PAIR_SER -- requirements
Module: word_pair_ser

Interface
REQ-001 Parameter: W, default 32, serialised word width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  request to accept din this cycle.
REQ-005 din  input  W  parallel word, LSB-pair first on line.
REQ-006 hold  input  1  freeze shifting; present outputs held.
REQ-007 ready  output  1  load accepted at next edge when high.
REQ-008 A  output  1  even bit of current pair (din[2k]), registered.
REQ-009 B  output  1  odd bit of current pair (din[2k+1]), registered.
REQ-010 frame  output  1  high while A/B carry a valid pair, registered.
REQ-011 last  output  1  high while final pair (k = W/2-1) is presented, registered.

Function
REQ-012 States SHALL be IDLE and SHIFT; pair counter k SHALL be clog2(W/2) bits wide, plus a W-bit shift register.
REQ-013 ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when k = W/2-1 and hold = 0; else 0.
REQ-014 load SHALL be accepted only on an edge where ready = 1; load when ready = 0 SHALL be ignored, with no state change.
REQ-015 On acceptance: at that edge A = din[0], B = din[1], frame = 1, k = 0, state = SHIFT; latency load-to-first-pair = 1 edge.
REQ-016 In SHIFT with hold = 0 and k < W/2-1: each edge SHALL advance k by 1 and present A = word[2k], B = word[2k+1].
REQ-017 In SHIFT with hold = 1: A, B, frame, last, k and the stored word SHALL all remain unchanged; hold has no effect in IDLE.
REQ-018 In IDLE, load SHALL be accepted regardless of hold.
REQ-019 last SHALL be 1 exactly while k = W/2-1 in SHIFT, and 0 otherwise.
REQ-020 At k = W/2-1 with hold = 0, next edge with load = 1: new word pair 0 presented; frame stays 1; no idle gap (back-to-back).
REQ-021 At k = W/2-1 with hold = 0, next edge with load = 0: state = IDLE, frame = 0, last = 0, A = B = 0.
REQ-022 In IDLE, A = B = frame = last = 0.
REQ-023 A full word SHALL occupy exactly W/2 frame-high cycles when hold stays 0.
REQ-024 Counter wrap SHALL never occur; k only returns to 0 via acceptance.
REQ-025 din is sampled only at the accepting edge; later din changes SHALL NOT affect the word in flight.

Reset
REQ-026 clr = 1 SHALL immediately force: state IDLE, k = 0, shift register 0, A = B = frame = last = 0.
REQ-027 While clr = 1, ready = 1 is permitted; load SHALL be ignored.
REQ-028 clr asserted mid-word SHALL discard the word; after release, the first pair appears only after a new accepted load.
REQ-029 Release of clr SHALL need no extra cycle: load sampled at the first edge after release is accepted.

Verification
REQ-030 W = 32, din = 0x37353AF2, single load, hold = 0 -> pairs (A,B): (0,1),(0,0),(1,1),(1,1),... over 16 cycles; frame high 16 cycles; last only on the 16th; then IDLE with A = B = 0.
REQ-031 Two loads, the second asserted while last = 1: din 0xFFFFFFFF then 0x00000000 -> 16 pairs of (1,1) then 16 of (0,0); frame continuously high for 32 cycles.
REQ-032 hold = 1 for 3 cycles at k = 5 -> A/B/k frozen 3 cycles; total frame-high = 19 cycles; pair order unchanged.
REQ-033 hold = 1 at k = 15 -> ready = 0, last stays 1; a load during hold is ignored; after hold drops, IDLE follows next edge.
REQ-034 clr pulsed at k = 8 -> outputs 0 immediately (asynchronous); no further pairs until a new load; the new word starts at pair 0.
REQ-035 load while k = 3 (ready = 0) with a different din -> ignored; current word completes unaltered.
